// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and the LSU (D).
// It arbitrates in IDLE and holds the grant until the memory accepts. It then tracks the
// single outstanding transaction and routes its response back to the owner.
//
// Optional feature: define MEM_ARB_PERF_CNT_EN to add grant and stall performance counters.
// Without it, the perf_* ports are tied to 0.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req_valid/ready, i_addr   fetch request (read only)
//   i_resp_valid, i_resp_rdata  fetch response (1-cycle valid pulse)
//   d_req_valid/ready, d_we, d_addr, d_wdata, d_wstrb   LSU request
//   d_resp_valid, d_resp_rdata  LSU response (pulses for stores too, as write ack)
//   m_req_valid/ready, m_we, m_addr, m_wdata, m_wstrb   muxed memory request
//   m_resp_valid, m_resp_rdata  memory response
//   stray_resp                  response seen with no transaction outstanding
//   perf_i_grants, perf_d_grants, perf_stall_cycles   performance counters
module mem_port_arbiter #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_resp_valid,
    output logic [XLEN-1:0]   i_resp_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_wstrb,
    output logic              d_resp_valid,
    output logic [XLEN-1:0]   d_resp_rdata,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic              m_we,
    output logic [XLEN-1:0]   m_addr,
    output logic [XLEN-1:0]   m_wdata,
    output logic [XLEN/8-1:0] m_wstrb,
    input  logic              m_resp_valid,
    input  logic [XLEN-1:0]   m_resp_rdata,
    output logic              stray_resp,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_stall_cycles
);

    // A zero-width counter is not legal, so keep at least one bit when MAX_DSTREAK is 0.
    localparam int unsigned StreakW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DSTREAK);

    typedef enum logic [2:0] {StIdle, StReqI, StReqD, StWaitI, StWaitD} state_e;

    state_e             state_q, state_d;
    logic [StreakW-1:0] streak_q, streak_d;

    logic idle, waiting, i_force, i_win, d_win, use_i, use_d, i_acc, d_acc;

    always_comb begin
        idle    = (state_q == StIdle);
        waiting = (state_q == StWaitI) || (state_q == StWaitD);
        // Anti-starvation: after MAX_DSTREAK back-to-back D wins with I waiting, I goes first.
        i_force = (MAX_DSTREAK != 0) && (streak_q == StreakMax);
        i_win   = i_req_valid & (~d_req_valid | i_force);
        d_win   = d_req_valid & ~i_win;
        // Once presented (REQ_x), the grant is locked to that requester.
        use_i   = (idle & i_win) | (state_q == StReqI);
        use_d   = (idle & d_win) | (state_q == StReqD);
        i_acc   = rst_n & use_i & m_req_ready;
        d_acc   = rst_n & use_d & m_req_ready;

        // Outputs: everything reads 0 while reset is held.
        m_req_valid  = 1'b0;
        m_we         = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
        m_wstrb      = '0;
        i_req_ready  = 1'b0;
        d_req_ready  = 1'b0;
        i_resp_valid = 1'b0;
        d_resp_valid = 1'b0;
        i_resp_rdata = '0;
        d_resp_rdata = '0;
        stray_resp   = 1'b0;
        if (rst_n) begin
            m_req_valid  = use_i | use_d;
            i_req_ready  = i_acc;
            d_req_ready  = d_acc;
            if (use_i) begin
                m_addr = i_addr;
            end else if (use_d) begin
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_wstrb = d_wstrb;
            end
            i_resp_valid = (state_q == StWaitI) & m_resp_valid;
            d_resp_valid = (state_q == StWaitD) & m_resp_valid;
            i_resp_rdata = m_resp_rdata;
            d_resp_rdata = m_resp_rdata;
            stray_resp   = m_resp_valid & ~waiting;
        end

        state_d = state_q;
        unique case (state_q)
            StIdle, StReqI, StReqD: begin
                if (i_acc)      state_d = StWaitI;
                else if (d_acc) state_d = StWaitD;
                else if (use_i) state_d = StReqI;
                else if (use_d) state_d = StReqD;
                else            state_d = StIdle;
            end
            StWaitI, StWaitD: begin
                if (m_resp_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        streak_d = streak_q;
        if (d_acc & i_req_valid) begin
            if (streak_q != StreakMax) streak_d = streak_q + 1'b1;
        end else if (i_acc | (idle & ~i_req_valid)) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_i_q, perf_d_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_i_q     <= '0;
            perf_d_q     <= '0;
            perf_stall_q <= '0;
        end else begin
            if (i_acc) perf_i_q <= perf_i_q + 32'd1;
            if (d_acc) perf_d_q <= perf_d_q + 32'd1;
            if ((i_req_valid & ~i_req_ready) | (d_req_valid & ~d_req_ready)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_i_grants     = perf_i_q;
    assign perf_d_grants     = perf_d_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    assign perf_i_grants     = '0;
    assign perf_d_grants     = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance u0 uses MAX_DSTREAK=4; instance u1 shares the
// same inputs with MAX_DSTREAK=0 and is only checked in the starvation scenario.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, d_req_valid, d_we, m_req_ready, m_resp_valid;
    logic [31:0] i_addr, d_addr, d_wdata, m_resp_rdata;
    logic [3:0]  d_wstrb;

    logic        i_req_ready, i_resp_valid, d_req_ready, d_resp_valid, m_req_valid, m_we;
    logic        stray_resp;
    logic [31:0] i_resp_rdata, d_resp_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] perf_i, perf_d, perf_s;

    logic        z_i_req_ready, z_i_resp_valid, z_d_req_ready, z_d_resp_valid, z_m_req_valid;
    logic        z_m_we, z_stray_resp;
    logic [31:0] z_i_resp_rdata, z_d_resp_rdata, z_m_addr, z_m_wdata;
    logic [3:0]  z_m_wstrb;
    logic [31:0] z_perf_i, z_perf_d, z_perf_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(32), .MAX_DSTREAK(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata), .stray_resp(stray_resp),
        .perf_i_grants(perf_i), .perf_d_grants(perf_d), .perf_stall_cycles(perf_s)
    );

    mem_port_arbiter #(.XLEN(32), .MAX_DSTREAK(0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(z_i_req_ready), .i_addr(i_addr),
        .i_resp_valid(z_i_resp_valid), .i_resp_rdata(z_i_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(z_d_req_ready), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_resp_valid(z_d_resp_valid), .d_resp_rdata(z_d_resp_rdata),
        .m_req_valid(z_m_req_valid), .m_req_ready(m_req_ready), .m_we(z_m_we),
        .m_addr(z_m_addr), .m_wdata(z_m_wdata), .m_wstrb(z_m_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
        .stray_resp(z_stray_resp),
        .perf_i_grants(z_perf_i), .perf_d_grants(z_perf_d), .perf_stall_cycles(z_perf_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req_valid  = 1'b0;
        d_req_valid  = 1'b0;
        d_we         = 1'b0;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        i_addr       = '0;
        d_addr       = '0;
        d_wdata      = '0;
        d_wstrb      = '0;
        m_resp_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Reset: outputs forced low even with a request and a response present.
        i_req_valid  = 1'b1;
        i_addr       = 32'h100;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("rst_m_req_valid", {31'd0, m_req_valid}, 32'd0);
        chk("rst_i_req_ready", {31'd0, i_req_ready}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_stray", {31'd0, stray_resp}, 32'd0);
        chk("rst_i_rdata", i_resp_rdata, 32'd0);
        tick();
        idle_inputs();
        rst_n = 1'b1;

        // Single fetch.
        i_req_valid = 1'b1;
        i_addr      = 32'h100;
        m_req_ready = 1'b1;
        @(negedge clk);
        chk("f_m_req_valid", {31'd0, m_req_valid}, 32'd1);
        chk("f_m_addr", m_addr, 32'h100);
        chk("f_m_we", {31'd0, m_we}, 32'd0);
        chk("f_i_req_ready", {31'd0, i_req_ready}, 32'd1);
        chk("f_d_req_ready", {31'd0, d_req_ready}, 32'd0);
        tick();
        i_req_valid  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("f_i_resp_valid", {31'd0, i_resp_valid}, 32'd1);
        chk("f_i_resp_rdata", i_resp_rdata, 32'hDEAD_BEEF);
        chk("f_d_resp_valid", {31'd0, d_resp_valid}, 32'd0);
        chk("f_wait_no_req", {31'd0, m_req_valid}, 32'd0);
        chk("f_no_stray", {31'd0, stray_resp}, 32'd0);
        tick();
        m_resp_valid = 1'b0;
        @(negedge clk);
        chk("f_resp_pulse", {31'd0, i_resp_valid}, 32'd0);

        // Collision: D store wins first, then I.
        do_reset();
        i_req_valid = 1'b1;
        i_addr      = 32'h200;
        d_req_valid = 1'b1;
        d_we        = 1'b1;
        d_addr      = 32'h8000;
        d_wdata     = 32'h55;
        d_wstrb     = 4'h1;
        m_req_ready = 1'b1;
        @(negedge clk);
        chk("c_m_addr_d", m_addr, 32'h8000);
        chk("c_m_we", {31'd0, m_we}, 32'd1);
        chk("c_m_wstrb", {28'd0, m_wstrb}, 32'h1);
        chk("c_m_wdata", m_wdata, 32'h55);
        chk("c_d_ready", {31'd0, d_req_ready}, 32'd1);
        chk("c_i_not_ready", {31'd0, i_req_ready}, 32'd0);
        tick();
        d_req_valid  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'h0;
        @(negedge clk);
        chk("c_d_ack", {31'd0, d_resp_valid}, 32'd1);
        chk("c_i_no_resp", {31'd0, i_resp_valid}, 32'd0);
        chk("c_i_wait_ready", {31'd0, i_req_ready}, 32'd0);
        tick();
        m_resp_valid = 1'b0;
        @(negedge clk);
        chk("c_m_addr_i", m_addr, 32'h200);
        chk("c_m_we_i", {31'd0, m_we}, 32'd0);
        chk("c_m_wstrb_i", {28'd0, m_wstrb}, 32'h0);
        chk("c_i_ready", {31'd0, i_req_ready}, 32'd1);
        tick();
        i_req_valid  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("c_i_resp", {31'd0, i_resp_valid}, 32'd1);
        chk("c_i_rdata", i_resp_rdata, 32'hCAFE_0001);
        tick();
        m_resp_valid = 1'b0;
        @(negedge clk);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_i", perf_i, 32'd1);
        chk("perf_d", perf_d, 32'd1);
        chk("perf_stall", perf_s, 32'd2);
`else
        chk("perf_i", perf_i, 32'd0);
        chk("perf_d", perf_d, 32'd0);
        chk("perf_stall", perf_s, 32'd0);
`endif

        // Back-pressure: D held 3 cycles, grant stays locked while I arrives.
        do_reset();
        d_req_valid = 1'b1;
        d_we        = 1'b0;
        d_addr      = 32'h3000;
        @(negedge clk);
        chk("bp_c0_addr", m_addr, 32'h3000);
        chk("bp_c0_valid", {31'd0, m_req_valid}, 32'd1);
        chk("bp_c0_ready", {31'd0, d_req_ready}, 32'd0);
        tick();
        i_req_valid = 1'b1;
        i_addr      = 32'h400;
        @(negedge clk);
        chk("bp_c1_addr", m_addr, 32'h3000);
        chk("bp_c1_i_ready", {31'd0, i_req_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("bp_c2_addr", m_addr, 32'h3000);
        chk("bp_c2_valid", {31'd0, m_req_valid}, 32'd1);
        tick();
        m_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_c3_addr", m_addr, 32'h3000);
        chk("bp_c3_d_ready", {31'd0, d_req_ready}, 32'd1);
        chk("bp_c3_i_ready", {31'd0, i_req_ready}, 32'd0);
        tick();
        d_req_valid  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'h1234;
        @(negedge clk);
        chk("bp_d_resp", {31'd0, d_resp_valid}, 32'd1);
        chk("bp_d_rdata", d_resp_rdata, 32'h1234);
        chk("bp_i_no_resp", {31'd0, i_resp_valid}, 32'd0);
        tick();
        m_resp_valid = 1'b0;
        @(negedge clk);
        chk("bp_i_addr", m_addr, 32'h400);
        chk("bp_i_ready", {31'd0, i_req_ready}, 32'd1);
        tick();
        i_req_valid  = 1'b0;
        m_resp_valid = 1'b1;
        @(negedge clk);
        chk("bp_i_resp", {31'd0, i_resp_valid}, 32'd1);
        tick();
        m_resp_valid = 1'b0;

        // Anti-starvation: both held valid, response every wait cycle.
        do_reset();
        i_req_valid  = 1'b1;
        i_addr       = 32'h500;
        d_req_valid  = 1'b1;
        d_addr       = 32'h600;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("s4_i_grant_%0d", k), {31'd0, i_req_ready}, {31'd0, (k % 5) == 4});
            chk($sformatf("s4_d_grant_%0d", k), {31'd0, d_req_ready}, {31'd0, (k % 5) != 4});
            chk($sformatf("s0_i_grant_%0d", k), {31'd0, z_i_req_ready}, 32'd0);
            chk($sformatf("s0_d_grant_%0d", k), {31'd0, z_d_req_ready}, 32'd1);
            tick();
            @(negedge clk);
            chk($sformatf("s4_wait_%0d", k), {31'd0, m_req_valid}, 32'd0);
            tick();
        end

        // Stray response after reset during WAIT_D.
        do_reset();
        d_req_valid = 1'b1;
        d_addr      = 32'h700;
        m_req_ready = 1'b1;
        tick();
        d_req_valid = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        chk("sr_rst_req_valid", {31'd0, m_req_valid}, 32'd0);
        chk("sr_rst_d_resp", {31'd0, d_resp_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("sr_no_d_resp", {31'd0, d_resp_valid}, 32'd0);
        chk("sr_stray", {31'd0, stray_resp}, 32'd1);
        tick();
        m_resp_valid = 1'b0;
        i_req_valid  = 1'b1;
        i_addr       = 32'h900;
        @(negedge clk);
        chk("sr_stray_pulse", {31'd0, stray_resp}, 32'd0);
        chk("sr_idle_grant", {31'd0, i_req_ready}, 32'd1);
        chk("sr_idle_addr", m_addr, 32'h900);
        tick();
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
